// File: rtl/bus_target_port.sv
// bus_target_port
//   Target-side responder for the arbitrated local bus. Decodes the granted
//   master's address against a 2**SPAN_LOG2 window at BASE_ADDR. It raises
//   TargetReady once the target can take the data strobe, and bridges each
//   transfer onto a simple local register port (Loc_*). All outputs are registered.
// Ports
//   clk, Reset                 clock (rising edge), async active-high reset
//   AddressValid/BusAddr/
//   BusWrite/BusWrData         granted transfer from the arbiter (level)
//   DataStrobe, Error          one-clock completion / abort pulses
//   TargetReady                decoded and ready for the strobe
//   BusRdData/BusRdValid       read return data and its drive enable
//   Loc_Addr/Loc_WrData/Loc_Wr local write port (one-clock write pulse)
//   Loc_Rd/Loc_RdData/Loc_Ack  local read request, data and acknowledge
module bus_target_port #(
    parameter int             AW          = 16,
    parameter int             DW          = 16,
    parameter int             SPAN_LOG2   = 4,
    parameter logic [AW-1:0]  BASE_ADDR   = '0,
    parameter int             WAIT_STATES = 0,
    parameter int             LOC_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 AddressValid,
    input  logic [AW-1:0]        BusAddr,
    input  logic                 BusWrite,
    input  logic [DW-1:0]        BusWrData,
    input  logic                 DataStrobe,
    input  logic                 Error,
    output logic                 TargetReady,
    output logic [DW-1:0]        BusRdData,
    output logic                 BusRdValid,
    output logic [SPAN_LOG2-1:0] Loc_Addr,
    output logic [DW-1:0]        Loc_WrData,
    output logic                 Loc_Wr,
    output logic                 Loc_Rd,
    input  logic [DW-1:0]        Loc_RdData,
    input  logic                 Loc_Ack
);

    typedef enum logic [2:0] {IDLE, LREAD, WAIT, READY, DONE, MISS} state_t;

    localparam int CMAX = (WAIT_STATES > LOC_TIMEOUT) ? WAIT_STATES : LOC_TIMEOUT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
    localparam logic [CW-1:0] WS_LAST = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [CW-1:0] TO_LAST = CW'((LOC_TIMEOUT > 0) ? LOC_TIMEOUT - 1 : 0);
    // With no wait states the WAIT state is skipped so TargetReady rises one
    // cycle after the decode (write) or the local ack (read).
    localparam state_t AFTER_DATA = (WAIT_STATES == 0) ? READY : WAIT;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic                  r_armed;
    logic                  r_write;
    logic                  r_ready, r_rdvalid, r_loc_wr, r_loc_rd;
    logic [DW-1:0]         r_rddata, r_loc_wrdata;
    logic [SPAN_LOG2-1:0]  r_loc_addr;

    logic                  w_hit, w_write_eff;
    logic                  w_ready_nxt, w_rdvalid_nxt, w_loc_wr_nxt, w_loc_rd_nxt;
    logic                  w_capture, w_rd_latch;

    assign w_hit = (BusAddr[AW-1:SPAN_LOG2] == BASE_ADDR[AW-1:SPAN_LOG2]);

    // State register plus the datapath registers that follow it
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_armed      <= 1'b0;
            r_write      <= 1'b0;
            r_ready      <= 1'b0;
            r_rdvalid    <= 1'b0;
            r_loc_wr     <= 1'b0;
            r_loc_rd     <= 1'b0;
            r_rddata     <= '0;
            r_loc_wrdata <= '0;
            r_loc_addr   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            // A grant is only decoded after AddressValid has been seen low in
            // IDLE, so a grant held across DONE/MISS is never re-decoded.
            r_armed   <= (r_state == IDLE) && !AddressValid;
            if ((w_state_nxt != r_state) || !((r_state == LREAD) || (r_state == WAIT)))
                r_cnt <= '0;
            else if (r_cnt != {CW{1'b1}})
                r_cnt <= r_cnt + CW'(1);
            if (w_capture) begin
                r_write      <= BusWrite;
                r_loc_addr   <= BusAddr[SPAN_LOG2-1:0];
                r_loc_wrdata <= BusWrData;
            end
            if (w_rd_latch)
                r_rddata <= Loc_RdData;
            else if ((w_state_nxt != WAIT) && (w_state_nxt != READY))
                r_rddata <= '0;
            r_ready   <= w_ready_nxt;
            r_rdvalid <= w_rdvalid_nxt;
            r_loc_wr  <= w_loc_wr_nxt;
            r_loc_rd  <= w_loc_rd_nxt;
        end
    end

    // Next-state logic; Error outranks the strobe, the strobe outranks AV falling
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (AddressValid && r_armed) begin
                    if (!w_hit)        w_state_nxt = MISS;
                    else if (BusWrite) w_state_nxt = AFTER_DATA;
                    else               w_state_nxt = LREAD;
                end
            end
            LREAD: begin
                if (Error)                  w_state_nxt = DONE;
                else if (!AddressValid)     w_state_nxt = IDLE;
                else if (Loc_Ack)           w_state_nxt = AFTER_DATA;
                else if (r_cnt == TO_LAST)  w_state_nxt = MISS;
            end
            WAIT: begin
                if (Error)                  w_state_nxt = DONE;
                else if (!AddressValid)     w_state_nxt = IDLE;
                else if (r_cnt == WS_LAST)  w_state_nxt = READY;
            end
            READY: begin
                if (Error || DataStrobe)    w_state_nxt = DONE;
                else if (!AddressValid)     w_state_nxt = IDLE;
            end
            DONE, MISS: begin
                if (!AddressValid)          w_state_nxt = IDLE;
            end
            default:                        w_state_nxt = IDLE;
        endcase
    end

    // Output next-values, registered above
    always_comb begin
        w_write_eff   = (r_state == IDLE) ? BusWrite : r_write;
        w_capture     = (r_state == IDLE) && (w_state_nxt != IDLE);
        w_rd_latch    = (r_state == LREAD) && ((w_state_nxt == WAIT) || (w_state_nxt == READY));
        w_ready_nxt   = (w_state_nxt == READY);
        w_rdvalid_nxt = (w_state_nxt == READY) && !w_write_eff;
        w_loc_rd_nxt  = (r_state == IDLE) && (w_state_nxt == LREAD);
        w_loc_wr_nxt  = (r_state == READY) && DataStrobe && !Error && r_write;
    end

    assign TargetReady = r_ready;
    assign BusRdValid  = r_rdvalid;
    assign BusRdData   = r_rddata;
    assign Loc_Wr      = r_loc_wr;
    assign Loc_Rd      = r_loc_rd;
    assign Loc_Addr    = r_loc_addr;
    assign Loc_WrData  = r_loc_wrdata;

endmodule
